// File: rtl/conway_pkg.sv
// Shared types and default widths for the Game-of-Life sequencer.
// Encodings match the status/halt_reason output codes.
package conway_pkg;

  localparam int PERIOD_W_DEF = 24;
  localparam int GEN_W_DEF    = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_STEP = 2'd3
  } ctrl_state_t;

  typedef enum logic [1:0] {
    HR_NONE    = 2'd0,
    HR_LIMIT   = 2'd1,
    HR_EXTINCT = 2'd2,
    HR_STABLE  = 2'd3
  } halt_reason_t;

endpackage

// File: rtl/conway_controller_tick_divider.sv
// Generation-rate divider: tick_o is combinational and registered by the
// caller, so a clear cycle counts as cycle 0 of the new run.
module tick_divider #(
  parameter int PERIOD_W = 24
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clear_i,
  input  logic                enable_i,
  input  logic [PERIOD_W-1:0] period_i,
  output logic                tick_o
);

  logic [PERIOD_W-1:0] cnt_q, cnt_d;
  logic [PERIOD_W-1:0] cur, last;

  always_comb begin
    last   = (period_i == '0) ? '0 : period_i - PERIOD_W'(1);
    cur    = clear_i ? '0 : cnt_q;
    tick_o = (clear_i | enable_i) && (cur >= last);
    cnt_d  = cnt_q;
    if (clear_i | enable_i)
      cnt_d = tick_o ? '0 : cur + PERIOD_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/conway_controller.sv
// Game-of-Life array sequencer: load/step/run FSM, generation
// counter and sticky halt detection (limit, extinction, stable).
module conway_controller
  import conway_pkg::*;
#(
  parameter int PERIOD_W = PERIOD_W_DEF,
  parameter int GEN_W    = GEN_W_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cmd_load,
  input  logic                cmd_run,
  input  logic                cmd_stop,
  input  logic                cmd_step,
  input  logic [PERIOD_W-1:0] period,
  input  logic [GEN_W-1:0]    gen_limit,
  input  logic                any_alive,
  input  logic                any_changed,
  output logic                cells_load,
  output logic                cells_ena,
  output logic [1:0]          status,
  output logic [1:0]          halt_reason,
  output logic [GEN_W-1:0]    generation
);

  ctrl_state_t  state_q, state_d;
  halt_reason_t halt_q, halt_d;
  logic [GEN_W-1:0] gen_q, gen_d, gen_inc;
  logic load_q, load_d;
  logic ena_q, ena_d;
  logic sel_load, sel_stop, sel_step, sel_run;
  logic limit_hit, eval_halt;
  logic div_clear, div_tick;

  assign sel_load = cmd_load;
  assign sel_stop = cmd_stop & ~cmd_load;
  assign sel_step = cmd_step & ~cmd_stop & ~cmd_load;
  assign sel_run  = cmd_run & ~cmd_step & ~cmd_stop & ~cmd_load;

  tick_divider #(
    .PERIOD_W (PERIOD_W)
  ) u_div (
    .clk      (clk),
    .rst_n    (rst),
    .clear_i  (div_clear),
    .enable_i (state_q == ST_RUN),
    .period_i (period),
    .tick_o   (div_tick)
  );

  always_comb begin
    state_d   = state_q;
    gen_d     = gen_q;
    halt_d    = halt_q;
    div_clear = 1'b0;
    eval_halt = 1'b0;
    gen_inc   = (gen_q == '1) ? gen_q : gen_q + GEN_W'(1);
    limit_hit = (gen_limit != '0) && (gen_q >= gen_limit);

    // any_alive/any_changed describe the generation being replaced
    if (ena_q) begin
      if (!any_alive) begin
        halt_d    = HR_EXTINCT;
        eval_halt = 1'b1;
      end else if (!any_changed) begin
        halt_d    = HR_STABLE;
        eval_halt = 1'b1;
      end else begin
        gen_d = gen_inc;
        if ((gen_limit != '0) && (gen_inc == gen_limit)) begin
          halt_d    = HR_LIMIT;
          eval_halt = 1'b1;
        end
      end
    end

    unique case (state_q)
      ST_IDLE: begin
        unique case (1'b1)
          sel_load: state_d = ST_LOAD;
          sel_step: state_d = ST_STEP;
          sel_run: begin
            if (limit_hit) begin
              halt_d = HR_LIMIT;
            end else begin
              state_d   = ST_RUN;
              halt_d    = HR_NONE;
              div_clear = 1'b1;
            end
          end
          default: ;
        endcase
      end
      ST_RUN: begin
        if (sel_load)
          state_d = ST_LOAD;
        else if (sel_stop || eval_halt)
          state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (state_d == ST_LOAD) begin
      gen_d  = '0;
      halt_d = HR_NONE;
    end

    load_d = (state_d == ST_LOAD);
    ena_d  = (state_d == ST_STEP) ||
             ((state_d == ST_RUN) && div_tick);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      halt_q  <= HR_NONE;
      gen_q   <= '0;
      load_q  <= 1'b0;
      ena_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      halt_q  <= halt_d;
      gen_q   <= gen_d;
      load_q  <= load_d;
      ena_q   <= ena_d;
    end
  end

  assign cells_load  = load_q;
  assign cells_ena   = ena_q;
  assign status      = state_q;
  assign halt_reason = halt_q;
  assign generation  = gen_q;

endmodule

// File: tb/tb_conway_controller.sv
// Self-checking bench for conway_controller: command vector table plus
// cycle-exact sequences for run rate, halts, async reset and saturation.
module tb_conway_controller;

  localparam int PW = 24;
  localparam int GW = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic cmd_load, cmd_run, cmd_stop, cmd_step;
  logic [PW-1:0] period;
  logic [GW-1:0] gen_limit;
  logic any_alive, any_changed;
  logic cells_load, cells_ena;
  logic [1:0] status, halt_reason;
  logic [GW-1:0] generation;

  always #5 clk = ~clk;

  conway_controller #(
    .PERIOD_W (PW),
    .GEN_W    (GW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .cmd_load    (cmd_load),
    .cmd_run     (cmd_run),
    .cmd_stop    (cmd_stop),
    .cmd_step    (cmd_step),
    .period      (period),
    .gen_limit   (gen_limit),
    .any_alive   (any_alive),
    .any_changed (any_changed),
    .cells_load  (cells_load),
    .cells_ena   (cells_ena),
    .status      (status),
    .halt_reason (halt_reason),
    .generation  (generation)
  );

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    string         name;
    logic          ld;
    logic          ena;
    logic [1:0]    st;
    logic [1:0]    hr;
    logic [GW-1:0] gen;
  } exp_t;

  exp_t sb[$];

  typedef struct {
    logic          c_load;
    logic          c_stop;
    logic          c_step;
    logic          c_run;
    logic          e_ld;
    logic          e_ena;
    logic [1:0]    e_st;
    logic [1:0]    e_hr;
    logic [GW-1:0] e_gen;
  } vec_t;

  vec_t tbl[6];

  task automatic push(input string nm, input logic ld, input logic ena,
                      input logic [1:0] st, input logic [1:0] hr,
                      input logic [GW-1:0] g);
    exp_t e;
    e.name = nm;
    e.ld   = ld;
    e.ena  = ena;
    e.st   = st;
    e.hr   = hr;
    e.gen  = g;
    sb.push_back(e);
  endtask

  task automatic drain();
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      n_chk++;
      if ({cells_load, cells_ena, status, halt_reason, generation} !==
          {e.ld, e.ena, e.st, e.hr, e.gen}) begin
        n_fail++;
        $display("FAIL %s: got load=%0b ena=%0b status=%0d halt=%0d gen=%0h, want load=%0b ena=%0b status=%0d halt=%0d gen=%0h",
                 e.name, cells_load, cells_ena, status, halt_reason,
                 generation, e.ld, e.ena, e.st, e.hr, e.gen);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cmd_load = 1'b0;
    cmd_run  = 1'b0;
    cmd_stop = 1'b0;
    cmd_step = 1'b0;
    drain();
  endtask

  task automatic do_load();
    cmd_load = 1'b1;
    tick();
    tick();
  endtask

  // Halt on the 3rd pulse of a period-2 run; extinct or stable.
  task automatic halt_seq(input bit extinct);
    logic [1:0] hr;
    hr = extinct ? 2'd2 : 2'd3;
    do_load();
    gen_limit = '0;
    period    = PW'(2);
    cmd_run   = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      push($sformatf("%s_c%0d", extinct ? "extinct" : "stable", k),
           1'b0, (k % 2 == 0) && (k <= 6),
           (k <= 6) ? 2'd2 : 2'd0,
           (k <= 6) ? 2'd0 : hr,
           GW'((k <= 6) ? (k - 1) / 2 : 2));
      tick();
      if (extinct) any_alive   = (k != 6);
      else         any_changed = (k != 6);
    end
    any_alive   = 1'b1;
    any_changed = 1'b1;
  endtask

  initial begin
    cmd_load    = 1'b0;
    cmd_run     = 1'b0;
    cmd_stop    = 1'b0;
    cmd_step    = 1'b0;
    period      = PW'(4);
    gen_limit   = '0;
    any_alive   = 1'b1;
    any_changed = 1'b1;

    tbl[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd1, 2'd0, 16'd0};
    tbl[1] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 16'd0};
    tbl[2] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 2'd3, 2'd0, 16'd0};
    tbl[3] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 16'd1};
    tbl[4] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'd1, 2'd0, 16'd0};
    tbl[5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 16'd0};

    #1;
    push("reset", 1'b0, 1'b0, 2'd0, 2'd0, '0);
    drain();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;

    for (int i = 0; i < 6; i++) begin
      cmd_load = tbl[i].c_load;
      cmd_stop = tbl[i].c_stop;
      cmd_step = tbl[i].c_step;
      cmd_run  = tbl[i].c_run;
      push($sformatf("vec%0d", i), tbl[i].e_ld, tbl[i].e_ena,
           tbl[i].e_st, tbl[i].e_hr, tbl[i].e_gen);
      tick();
    end

    period  = PW'(4);
    cmd_run = 1'b1;
    for (int k = 1; k <= 13; k++) begin
      push($sformatf("run4_c%0d", k), 1'b0, (k % 4 == 0), 2'd2, 2'd0,
           GW'((k - 1) / 4));
      tick();
    end
    cmd_stop = 1'b1;
    push("stop", 1'b0, 1'b0, 2'd0, 2'd0, GW'(3));
    tick();
    push("stop_hold", 1'b0, 1'b0, 2'd0, 2'd0, GW'(3));
    tick();

    do_load();
    gen_limit = GW'(5);
    period    = PW'(1);
    cmd_run   = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      push($sformatf("limit_c%0d", k), 1'b0, (k <= 5),
           (k <= 5) ? 2'd2 : 2'd0,
           (k <= 5) ? 2'd0 : 2'd1,
           GW'((k <= 5) ? k - 1 : 5));
      tick();
    end
    cmd_run = 1'b1;
    push("run_at_limit", 1'b0, 1'b0, 2'd0, 2'd1, GW'(5));
    tick();

    halt_seq(1'b0);
    halt_seq(1'b1);

    do_load();
    gen_limit = '0;
    period    = PW'(1);
    cmd_run   = 1'b1;
    tick();
    tick();
    push("ena_before_rst", 1'b0, 1'b1, 2'd2, 2'd0, GW'(1));
    drain();
    #2;
    rst = 1'b0;
    #1;
    push("async_rst", 1'b0, 1'b0, 2'd0, 2'd0, '0);
    drain();
    @(negedge clk);
    rst = 1'b1;

    do_load();
    gen_limit = '0;
    period    = PW'(1);
    cmd_run   = 1'b1;
    for (int k = 1; k <= 65538; k++) begin
      if (k >= 65535)
        push($sformatf("sat_c%0d", k), 1'b0, 1'b1, 2'd2, 2'd0,
             (k == 65535) ? 16'hFFFE : 16'hFFFF);
      tick();
    end
    cmd_stop = 1'b1;
    push("sat_stop", 1'b0, 1'b0, 2'd0, 2'd0, 16'hFFFF);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
